// File: rtl/nabp_sinogram_strided_addresser.sv
// Sinogram addresser with a programmable start angle and stride: walks the projection angles
// for the filtered RAM and maps (angle, s) to a registered flat sinogram RAM address.
module nabp_sinogram_strided_addresser #(
  parameter int unsigned NO_OF_ANGLES = 180,
  parameter int unsigned LINE_SIZE    = 256,
  parameter int unsigned ANGLE_W      = 8,
  parameter int unsigned S_W          = 9,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_hs_kick,
  input  logic               i_hs_abort,
  input  logic [ANGLE_W-1:0] i_cfg_start_angle,
  input  logic [ANGLE_W-1:0] i_cfg_angle_step,
  input  logic [S_W-1:0]     i_fr_s_val,
  input  logic               i_fr_s_valid,
  input  logic               i_fr_next_angle,
  output logic               o_hs_busy,
  output logic               o_hs_done,
  output logic               o_hs_err,
  output logic [ANGLE_W-1:0] o_fr_angle,
  output logic               o_fr_has_next_angle,
  output logic               o_fr_next_angle_ack,
  output logic [ANGLE_W-1:0] o_angle_count,
  output logic [ADDR_W-1:0]  o_sg_addr,
  output logic               o_sg_addr_valid,
  output logic               o_sg_oob
);

  localparam int unsigned AW1 = ANGLE_W + 1;
  localparam int unsigned SW1 = S_W + 1;

  typedef enum logic [1:0] {ST_READY, ST_INIT, ST_WORK} state_t;

  state_t             r_state;
  logic [ANGLE_W-1:0] r_start;
  logic [ANGLE_W-1:0] r_step;
  logic [ANGLE_W-1:0] r_angle;
  logic [ANGLE_W-1:0] r_angle_count;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_stride_off;
  logic [ADDR_W-1:0]  r_sg_addr;
  logic               r_sg_valid;
  logic               r_sg_oob;
  logic               r_done_pend;
  logic               r_done;
  logic               r_err;

  logic               w_work;
  logic [AW1-1:0]     w_next_sum;
  logic               w_has_next;
  logic               w_cfg_bad;
  logic               w_s_in_range;

  // One-bit-wider sum so start+step never wraps back into the legal angle range
  assign w_work       = (r_state == ST_WORK);
  assign w_next_sum   = AW1'(r_angle) + AW1'(r_step);
  assign w_has_next   = w_work && (w_next_sum < AW1'(NO_OF_ANGLES));
  assign w_cfg_bad    = (i_cfg_angle_step == '0) ||
                        (AW1'(i_cfg_start_angle) >= AW1'(NO_OF_ANGLES));
  assign w_s_in_range = (SW1'(i_fr_s_val) < SW1'(LINE_SIZE));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= ST_READY;
      r_start       <= '0;
      r_step        <= '0;
      r_angle       <= '0;
      r_angle_count <= '0;
      r_base        <= '0;
      r_stride_off  <= '0;
      r_sg_addr     <= '0;
      r_sg_valid    <= 1'b0;
      r_sg_oob      <= 1'b0;
      r_done_pend   <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done      <= r_done_pend;
      r_err       <= 1'b0;
      r_done_pend <= 1'b0;
      r_sg_addr   <= r_base + ADDR_W'(i_fr_s_val);
      r_sg_valid  <= i_fr_s_valid && w_work && w_s_in_range;
      r_sg_oob    <= i_fr_s_valid && w_work && !w_s_in_range;

      case (r_state)
        ST_READY: begin
          if (i_hs_kick) begin
            if (w_cfg_bad) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_start <= i_cfg_start_angle;
              r_step  <= i_cfg_angle_step;
              r_state <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          if (i_hs_abort) begin
            r_state <= ST_READY;
          end else begin
            r_angle       <= r_start;
            r_base        <= ADDR_W'(r_start) * ADDR_W'(LINE_SIZE);
            r_stride_off  <= ADDR_W'(r_step) * ADDR_W'(LINE_SIZE);
            r_angle_count <= '0;
            r_state       <= ST_WORK;
          end
        end
        ST_WORK: begin
          // Abort wins over an advance request in the same cycle
          if (i_hs_abort) begin
            r_state <= ST_READY;
          end else if (i_fr_next_angle) begin
            r_angle_count <= r_angle_count + ANGLE_W'(1);
            if (w_has_next) begin
              r_angle <= r_angle + r_step;
              r_base  <= r_base + r_stride_off;
            end else begin
              r_done_pend <= 1'b1;
              r_state     <= ST_READY;
            end
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  assign o_hs_busy           = (r_state == ST_INIT) || w_work;
  assign o_hs_done           = r_done;
  assign o_hs_err            = r_err;
  assign o_fr_angle          = r_angle;
  assign o_fr_has_next_angle = w_has_next;
  assign o_fr_next_angle_ack = w_has_next && i_fr_next_angle && !i_hs_abort;
  assign o_angle_count       = r_angle_count;
  assign o_sg_addr           = r_sg_addr;
  assign o_sg_addr_valid     = r_sg_valid;
  assign o_sg_oob            = r_sg_oob;

endmodule

// File: tb/tb_nabp_sinogram_strided_addresser.sv
// Directed bench for nabp_sinogram_strided_addresser (180 angles, 256-sample lines).
module tb_nabp_sinogram_strided_addresser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hs_kick, hs_abort;
  logic [7:0]  cfg_start_angle, cfg_angle_step;
  logic [8:0]  fr_s_val;
  logic        fr_s_valid, fr_next_angle;
  logic        hs_busy, hs_done, hs_err;
  logic [7:0]  fr_angle, angle_count;
  logic        fr_has_next_angle, fr_next_angle_ack;
  logic [15:0] sg_addr;
  logic        sg_addr_valid, sg_oob;

  int n_tests = 0;
  int n_fail  = 0;
  int acks;

  always #5 clk = ~clk;

  nabp_sinogram_strided_addresser dut (
    .i_clk               (clk),
    .i_reset_n           (reset_n),
    .i_hs_kick           (hs_kick),
    .i_hs_abort          (hs_abort),
    .i_cfg_start_angle   (cfg_start_angle),
    .i_cfg_angle_step    (cfg_angle_step),
    .i_fr_s_val          (fr_s_val),
    .i_fr_s_valid        (fr_s_valid),
    .i_fr_next_angle     (fr_next_angle),
    .o_hs_busy           (hs_busy),
    .o_hs_done           (hs_done),
    .o_hs_err            (hs_err),
    .o_fr_angle          (fr_angle),
    .o_fr_has_next_angle (fr_has_next_angle),
    .o_fr_next_angle_ack (fr_next_angle_ack),
    .o_angle_count       (angle_count),
    .o_sg_addr           (sg_addr),
    .o_sg_addr_valid     (sg_addr_valid),
    .o_sg_oob            (sg_oob)
  );

  typedef struct {
    logic [7:0]  start;
    logic [7:0]  step;
    int          n_adv;
    logic [8:0]  s;
    logic [7:0]  exp_angle;
    logic        exp_has_next;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic        exp_oob;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Kick with a legal config and step through INIT into WORK
  task automatic start_run(input logic [7:0] start, input logic [7:0] step);
    cfg_start_angle = start;
    cfg_angle_step  = step;
    hs_kick = 1'b1;
    tick();
    hs_kick = 1'b0;
    tick();
  endtask

  task automatic advance(input string name, input logic exp_ack);
    fr_next_angle = 1'b1;
    #1;
    chk(name, 32'(fr_next_angle_ack), 32'(exp_ack));
    tick();
    fr_next_angle = 1'b0;
  endtask

  task automatic do_abort();
    hs_abort = 1'b1;
    tick();
    hs_abort = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd3,   8'd4,   1, 9'd10,  8'd7,   1'b1, 16'd1802,  1'b1, 1'b0};
    vecs[1] = '{8'd0,   8'd1,   0, 9'd256, 8'd0,   1'b1, 16'd256,   1'b0, 1'b1};
    vecs[2] = '{8'd179, 8'd1,   0, 9'd255, 8'd179, 1'b0, 16'd46079, 1'b1, 1'b0};
    vecs[3] = '{8'd10,  8'd20,  3, 9'd0,   8'd70,  1'b1, 16'd17920, 1'b1, 1'b0};
    vecs[4] = '{8'd100, 8'd50,  1, 9'd511, 8'd150, 1'b0, 16'd38911, 1'b0, 1'b1};
    vecs[5] = '{8'd0,   8'd255, 0, 9'd5,   8'd0,   1'b0, 16'd5,     1'b1, 1'b0};

    reset_n = 1'b0; hs_kick = 1'b0; hs_abort = 1'b0;
    cfg_start_angle = '0; cfg_angle_step = '0;
    fr_s_val = '0; fr_s_valid = 1'b0; fr_next_angle = 1'b0;
    tick(); tick();
    chk("reset_busy",  32'(hs_busy), 0);
    chk("reset_done",  32'(hs_done), 0);
    chk("reset_angle", 32'(fr_angle), 0);
    chk("reset_addr",  32'(sg_addr), 0);
    reset_n = 1'b1;
    tick();

    // Table: run to an angle, request one s, check the address path, abort
    for (int i = 0; i < 6; i++) begin
      start_run(vecs[i].start, vecs[i].step);
      chk($sformatf("v%0d_busy", i), 32'(hs_busy), 1);
      for (int k = 0; k < vecs[i].n_adv; k++) advance($sformatf("v%0d_ack%0d", i, k), 1'b1);
      chk($sformatf("v%0d_angle", i), 32'(fr_angle), 32'(vecs[i].exp_angle));
      chk($sformatf("v%0d_has_next", i), 32'(fr_has_next_angle), 32'(vecs[i].exp_has_next));
      chk($sformatf("v%0d_count", i), 32'(angle_count), 32'(vecs[i].n_adv));
      fr_s_val = vecs[i].s; fr_s_valid = 1'b1;
      tick();
      fr_s_valid = 1'b0;
      chk($sformatf("v%0d_addr", i), 32'(sg_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_valid", i), 32'(sg_addr_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_oob", i), 32'(sg_oob), 32'(vecs[i].exp_oob));
      do_abort();
      chk($sformatf("v%0d_abort_busy", i), 32'(hs_busy), 0);
      chk($sformatf("v%0d_abort_valid", i), 32'(sg_addr_valid), 0);
      tick();
      chk($sformatf("v%0d_abort_done", i), 32'(hs_done), 0);
    end

    // Full run: 179 acked advances, then the terminal one
    start_run(8'd0, 8'd1);
    acks = 0;
    for (int k = 0; k < 179; k++) begin
      fr_next_angle = 1'b1;
      #1;
      if (fr_next_angle_ack) acks++;
      tick();
    end
    fr_next_angle = 1'b0;
    chk("full_acks", 32'(acks), 179);
    chk("full_angle", 32'(fr_angle), 179);
    chk("full_count179", 32'(angle_count), 179);
    fr_s_val = 9'd0; fr_s_valid = 1'b1;
    tick();
    fr_s_valid = 1'b0;
    chk("full_base", 32'(sg_addr), 45824);
    advance("full_last_ack", 1'b0);
    chk("full_ready", 32'(hs_busy), 0);
    chk("full_done_early", 32'(hs_done), 0);
    chk("full_count180", 32'(angle_count), 180);
    tick();
    chk("full_done", 32'(hs_done), 1);
    chk("full_err", 32'(hs_err), 0);
    tick();
    chk("full_done_width", 32'(hs_done), 0);

    // Illegal configs: immediate done+err, never busy
    for (int e = 0; e < 2; e++) begin
      cfg_start_angle = (e == 0) ? 8'd5 : 8'd180;
      cfg_angle_step  = (e == 0) ? 8'd0 : 8'd1;
      hs_kick = 1'b1;
      tick();
      hs_kick = 1'b0;
      chk($sformatf("bad%0d_busy", e), 32'(hs_busy), 0);
      chk($sformatf("bad%0d_done", e), 32'(hs_done), 1);
      chk($sformatf("bad%0d_err", e), 32'(hs_err), 1);
      tick();
      chk($sformatf("bad%0d_done_off", e), 32'(hs_done), 0);
      chk($sformatf("bad%0d_err_off", e), 32'(hs_err), 0);
      chk($sformatf("bad%0d_busy2", e), 32'(hs_busy), 0);
    end

    // Abort coincident with an advance at angle 50
    start_run(8'd0, 8'd10);
    for (int k = 0; k < 5; k++) advance($sformatf("ab_ack%0d", k), 1'b1);
    chk("ab_angle", 32'(fr_angle), 50);
    fr_next_angle = 1'b1; hs_abort = 1'b1;
    #1;
    chk("ab_no_ack", 32'(fr_next_angle_ack), 0);
    tick();
    fr_next_angle = 1'b0; hs_abort = 1'b0;
    chk("ab_ready", 32'(hs_busy), 0);
    tick();
    chk("ab_no_done", 32'(hs_done), 0);
    start_run(8'd7, 8'd1);
    chk("rekick_angle", 32'(fr_angle), 7);
    chk("rekick_count", 32'(angle_count), 0);

    // Kick while working is ignored
    cfg_start_angle = 8'd20; cfg_angle_step = 8'd3; hs_kick = 1'b1;
    tick();
    hs_kick = 1'b0;
    chk("kick_work_busy", 32'(hs_busy), 1);
    chk("kick_work_angle", 32'(fr_angle), 7);

    // s request alongside an advance uses the old base
    fr_s_val = 9'd3; fr_s_valid = 1'b1; fr_next_angle = 1'b1;
    tick();
    fr_s_valid = 1'b0; fr_next_angle = 1'b0;
    chk("same_cyc_addr", 32'(sg_addr), 1795);
    chk("same_cyc_valid", 32'(sg_addr_valid), 1);
    chk("same_cyc_angle", 32'(fr_angle), 8);

    // Reset mid-run clears everything with no done pulse
    fr_s_val = 9'd4; fr_s_valid = 1'b1; reset_n = 1'b0;
    tick();
    fr_s_valid = 1'b0;
    chk("rst_busy", 32'(hs_busy), 0);
    chk("rst_angle", 32'(fr_angle), 0);
    chk("rst_count", 32'(angle_count), 0);
    chk("rst_addr", 32'(sg_addr), 0);
    chk("rst_valid", 32'(sg_addr_valid), 0);
    chk("rst_has_next", 32'(fr_has_next_angle), 0);
    reset_n = 1'b1;
    tick();
    chk("rst_no_done", 32'(hs_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
